// File: rtl/stereo_ram_pkg.sv
// Shared types for the stereo RAM pixel path: pixel word, fetch FSM states.
// Default RAM word-address width used by the fetch engine.
package stereo_ram_pkg;

    localparam int ADDR_W_DEF = 26;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } rgb_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN
    } fetch_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous pixel FIFO with occupancy count and flush.
// DEPTH must be a power of two, at least 2.
module pixel_fifo
    import stereo_ram_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  rgb_t                   din,
    input  logic                   pop,
    output rgb_t                   dout,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    rgb_t          mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && (cnt_q != '0);
    assign do_push = push && ((cnt_q != FULL) || do_pop);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + 1'b1;
            if (do_pop)  rd_d = rd_q + 1'b1;
            cnt_d = cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_q] <= din;
    end

    assign dout  = mem_q[rd_q];
    assign count = cnt_q;

endmodule

// File: rtl/pixel_fetch.sv
// Frame pixel fetch engine: one-outstanding RAM reads into a pixel FIFO.
// Optional read timeout with sticky err: define PIXEL_FETCH_TIMEOUT_EN.
module pixel_fetch
    import stereo_ram_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int FRAME_PIXELS = 307200,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic              pixclk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              re_ram,
    output logic [ADDR_W-1:0] addr,
    input  logic              data_ready,
    input  logic [7:0]        red_in,
    input  logic [7:0]        green_in,
    input  logic [7:0]        blue_in,
    output logic [23:0]       pix_rgb,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              err
);

    localparam int IW = $clog2(FRAME_PIXELS + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [IW-1:0] LAST  = IW'(FRAME_PIXELS - 1);
    localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] ONE   = CW'(1);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              re_q, re_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              push, pop, flush;
    logic [CW-1:0]     count;
    rgb_t              head;
    rgb_t              din;
`ifdef PIXEL_FETCH_TIMEOUT_EN
    logic              err_q, err_d;
    logic [7:0]        tmo_q, tmo_d;
`endif

    assign din       = '{red: red_in, green: green_in, blue: blue_in};
    assign pix_valid = (count != '0);
    assign pop       = pix_valid && pix_ready;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        idx_d   = idx_q;
        re_d    = re_q;
        addr_d  = addr_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        push    = 1'b0;
        flush   = 1'b0;
`ifdef PIXEL_FETCH_TIMEOUT_EN
        err_d   = err_q;
        tmo_d   = tmo_q;
`endif
        unique case (state_q)
            IDLE: if (start) begin
                // Buffer is always empty here, so the first read issues at once.
                base_d  = base_addr;
                idx_d   = '0;
                busy_d  = 1'b1;
                re_d    = 1'b1;
                addr_d  = base_addr;
                state_d = WAIT;
`ifdef PIXEL_FETCH_TIMEOUT_EN
                err_d   = 1'b0;
                tmo_d   = '0;
`endif
            end
            REQ: if (count < DEPTH) begin
                re_d    = 1'b1;
                addr_d  = base_q + ADDR_W'(idx_q);
                state_d = WAIT;
`ifdef PIXEL_FETCH_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            WAIT: if (data_ready) begin
                push    = 1'b1;
                re_d    = 1'b0;
                idx_d   = idx_q + 1'b1;
                state_d = (idx_q == LAST) ? DRAIN : REQ;
            end
`ifdef PIXEL_FETCH_TIMEOUT_EN
            else if (tmo_q == 8'd254) begin
                re_d    = 1'b0;
                err_d   = 1'b1;
                flush   = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end else begin
                tmo_d   = tmo_q + 8'd1;
            end
`endif
            DRAIN: if (pop && count == ONE) begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pixclk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            base_q  <= '0;
            idx_q   <= '0;
            re_q    <= 1'b0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef PIXEL_FETCH_TIMEOUT_EN
            err_q   <= 1'b0;
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            idx_q   <= idx_d;
            re_q    <= re_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef PIXEL_FETCH_TIMEOUT_EN
            err_q   <= err_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (pixclk),
        .rst_n (reset),
        .flush (flush),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .dout  (head),
        .count (count)
    );

    assign re_ram     = re_q;
    assign addr       = addr_q;
    assign pix_rgb    = head;
    assign busy       = busy_q;
    assign frame_done = done_q;
`ifdef PIXEL_FETCH_TIMEOUT_EN
    assign err        = err_q;
`else
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_fetch.sv
// Random-stimulus bench for pixel_fetch: a RAM responder plus a pixel queue model.
// Unit 0 fetches 4-pixel frames, unit 1 fetches 12-pixel frames.
module tb_pixel_fetch;

    logic        pixclk = 1'b0;
    logic        reset  = 1'b0;
    logic [1:0]  start, re_ram, data_ready, pix_valid;
    logic [1:0]  pix_ready, busy, frame_done, err;
    logic [25:0] base_addr [2];
    logic [25:0] addr [2];
    logic [7:0]  red [2];
    logic [7:0]  green [2];
    logic [7:0]  blue [2];
    logic [23:0] pix_rgb [2];

    int n_cmp = 0;
    int n_bad = 0;
    logic [23:0] expq [$];

    always #5 pixclk = ~pixclk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        pixel_fetch #(
            .ADDR_W       (26),
            .FRAME_PIXELS ((g == 0) ? 4 : 12),
            .FIFO_DEPTH   (8)
        ) u_dut (
            .pixclk     (pixclk),
            .reset      (reset),
            .start      (start[g]),
            .base_addr  (base_addr[g]),
            .re_ram     (re_ram[g]),
            .addr       (addr[g]),
            .data_ready (data_ready[g]),
            .red_in     (red[g]),
            .green_in   (green[g]),
            .blue_in    (blue[g]),
            .pix_rgb    (pix_rgb[g]),
            .pix_valid  (pix_valid[g]),
            .pix_ready  (pix_ready[g]),
            .busy       (busy[g]),
            .frame_done (frame_done[g]),
            .err        (err[g])
        );
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // rmode: 0 always ready, 1 random ready, 2 stalled for 40 cycles.
    // abort_k >= 0: assert reset while read k is outstanding.
    task automatic run_frame(input int u, input logic [25:0] base,
                             input int n, input int fixdly,
                             input int rmode, input int abort_k);
        int k = 0, acc = 0, dones = 0, dly = 0, cyc = 0;
        bit act = 0, dropchk = 0, fin = 0;
        logic [25:0] ea = '0;
        logic [23:0] px;
        expq.delete();
        @(negedge pixclk);
        base_addr[u] = base;
        start[u] = 1'b1;
        @(negedge pixclk);
        start[u] = 1'b0;
        chk("lat_start", re_ram[u], 1);
        chk("busy_set", busy[u], 1);
        while (!fin && cyc < 3000) begin
            cyc++;
            data_ready[u] = 1'b0;
            chk("valid", pix_valid[u], expq.size() != 0);
            if (pix_valid[u] && expq.size() != 0)
                chk("rgb", pix_rgb[u], expq[0]);
            if (frame_done[u]) begin
                dones++;
                chk("done_acc", acc, n);
                chk("busy_clr", busy[u], 0);
                fin = 1;
            end
            if (dropchk) begin
                chk("re_drop", re_ram[u], 0);
                dropchk = 0;
                act = 0;
            end else if (act) begin
                chk("re_hold", re_ram[u], 1);
                chk("addr_hold", addr[u], ea);
            end else if (re_ram[u]) begin
                ea = 26'((64'(base) + 64'(k)) % 64'h400_0000);
                chk("addr", addr[u], ea);
                chk("room", expq.size() < 8, 1);
                chk("nreads", k < n, 1);
                act = 1;
                dly = (fixdly >= 0) ? fixdly : int'($urandom_range(0, 4));
            end
            if (abort_k >= 0 && k == abort_k && act && !dropchk) begin
                reset = 1'b0;
                @(posedge pixclk);
                #1;
                chk("rst_re", re_ram[u], 0);
                chk("rst_addr", addr[u], 0);
                chk("rst_valid", pix_valid[u], 0);
                chk("rst_busy", busy[u], 0);
                chk("rst_done", frame_done[u], 0);
                @(negedge pixclk);
                reset = 1'b1;
                return;
            end
            case (rmode)
                0:       pix_ready[u] = 1'b1;
                1:       pix_ready[u] = ($urandom_range(0, 9) < 7);
                default: pix_ready[u] = (cyc > 40);
            endcase
            if (rmode == 2 && cyc == 40) begin
                chk("stall_reads", k, 8);
                chk("stall_re", re_ram[u], 0);
            end
            if (pix_valid[u] && pix_ready[u] && expq.size() != 0) begin
                void'(expq.pop_front());
                acc++;
            end
            if (act && !dropchk) begin
                if (dly == 0) begin
                    px = 24'($urandom);
                    red[u]   = px[23:16];
                    green[u] = px[15:8];
                    blue[u]  = px[7:0];
                    data_ready[u] = 1'b1;
                    expq.push_back(px);
                    k++;
                    dropchk = 1;
                end else begin
                    dly--;
                end
            end
            @(negedge pixclk);
        end
        chk("finish", fin, 1);
        data_ready[u] = 1'b0;
        pix_ready[u] = 1'b0;
        repeat (3) begin
            if (frame_done[u]) dones++;
            @(negedge pixclk);
        end
        chk("done_cnt", dones, 1);
        chk("busy_end", busy[u], 0);
        chk("reads", k, n);
        chk("pixels", acc, n);
        chk("err_zero", err[u], 0);
    endtask

`ifdef PIXEL_FETCH_TIMEOUT_EN
    task automatic timeout_test();
        int hi = 0, dn = 0;
        @(negedge pixclk);
        base_addr[0] = 26'h40;
        start[0] = 1'b1;
        @(negedge pixclk);
        start[0] = 1'b0;
        while (re_ram[0] && hi < 400) begin
            hi++;
            if (frame_done[0]) dn++;
            @(negedge pixclk);
        end
        chk("to_cycles", hi, 255);
        chk("to_err", err[0], 1);
        chk("to_busy", busy[0], 0);
        chk("to_done", dn + int'(frame_done[0]), 0);
        chk("to_valid", pix_valid[0], 0);
        start[0] = 1'b1;
        @(negedge pixclk);
        start[0] = 1'b0;
        chk("err_clr", err[0], 0);
        reset = 1'b0;
        @(negedge pixclk);
        reset = 1'b1;
    endtask
`endif

    initial begin
        start = '0;
        data_ready = '0;
        pix_ready = '0;
        for (int i = 0; i < 2; i++) begin
            base_addr[i] = '0;
            red[i] = '0;
            green[i] = '0;
            blue[i] = '0;
        end
        repeat (2) @(negedge pixclk);
        for (int i = 0; i < 2; i++) begin
            chk("init_re", re_ram[i], 0);
            chk("init_addr", addr[i], 0);
            chk("init_valid", pix_valid[i], 0);
            chk("init_busy", busy[i], 0);
            chk("init_done", frame_done[i], 0);
            chk("init_err", err[i], 0);
        end
        reset = 1'b1;
        @(negedge pixclk);
        run_frame(0, 26'h100, 4, 3, 0, -1);
        run_frame(1, 26'h2000, 12, 1, 2, -1);
        run_frame(0, 26'h3FF_FFFE, 4, -1, 1, -1);
        run_frame(0, 26'h55, 4, -1, 1, 2);
        run_frame(0, 26'h55, 4, -1, 1, -1);
        for (int i = 0; i < 6; i++)
            run_frame(i % 2, 26'($urandom), (i % 2) ? 12 : 4, -1, 1, -1);
`ifdef PIXEL_FETCH_TIMEOUT_EN
        timeout_test();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pixel_fetch.md
PIXEL_FETCH -- requirements
Module: pixel_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 26, RAM word-address width.
REQ-002 SHALL have parameter FRAME_PIXELS, default 307200, pixels read per frame.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, output buffer depth; power of two, at least 2.
REQ-004 SHALL use one clock and an asynchronous, active-low reset; ports listed below.
REQ-005 pixclk  in  1  sole clock; all logic on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  frame-fetch request pulse.
REQ-008 base_addr  in  ADDR_W  first pixel address.
REQ-009 re_ram  out  1  read request to RAM controller.
REQ-010 addr  out  ADDR_W  read address.
REQ-011 data_ready  in  1  one-cycle read-data-valid strobe from controller.
REQ-012 red_in, green_in, blue_in  in  8 each  read pixel data, valid with data_ready.
REQ-013 pix_rgb  out  24  {red,green,blue} head of output buffer.
REQ-014 pix_valid  out  1  pix_rgb valid.
REQ-015 pix_ready  in  1  downstream accepts pixel.
REQ-016 busy  out  1  frame in progress.
REQ-017 frame_done  out  1  one-cycle pulse when the last pixel is accepted downstream.
REQ-018 err  out  1  sticky read-timeout flag (TIMEOUT build only, else tied 0).

Function
REQ-019 FSM states SHALL be IDLE, REQ, WAIT and DRAIN.
REQ-020 IDLE: start high SHALL latch base_addr, clear index and err, set busy and go to REQ; start in any other state SHALL be ignored.
REQ-021 REQ: when buffer count is below FIFO_DEPTH, SHALL drive re_ram=1 with addr=base+index (mod 2^ADDR_W) on the next cycle and go to WAIT.
REQ-022 WAIT: re_ram and addr SHALL be held stable until data_ready is sampled high; re_ram SHALL be low on the following cycle.
REQ-023 Only one read SHALL be outstanding at a time; data_ready outside WAIT SHALL be ignored.
REQ-024 data_ready in WAIT SHALL push {red_in,green_in,blue_in}, increment index and go to REQ, or to DRAIN if index reaches FRAME_PIXELS.
REQ-025 Latency: start at cycle 0 SHALL give re_ram=1 at cycle 1; data_ready at cycle n SHALL give pix_valid=1 at cycle n+1.
REQ-026 pix_valid SHALL equal buffer not-empty; a pop SHALL occur when pix_valid and pix_ready are both high; simultaneous push and pop SHALL leave count unchanged.
REQ-027 DRAIN: the pop of the last buffered pixel SHALL pulse frame_done, clear busy and return to IDLE.
REQ-028 pix_rgb SHALL be stable while pix_valid=1 and pix_ready=0.

Reset
REQ-029 Reset assertion SHALL force IDLE, re_ram=0, addr=0, buffer empty, pix_valid=0, busy=0, frame_done=0, err=0, even mid-frame.

Configuration
REQ-030 Macro PIXEL_FETCH_TIMEOUT_EN defined: an 8-bit WAIT counter SHALL, after 255 cycles without data_ready, drop re_ram, set err, flush the buffer, clear busy and go to IDLE without frame_done.
REQ-031 Macro PIXEL_FETCH_TIMEOUT_EN undefined: WAIT SHALL wait indefinitely and err SHALL be constant 0.

Structure
REQ-032 Shared package stereo_ram_pkg SHALL hold ADDR_W default, the 24-bit RGB pixel typedef and the fetch-state enum.
REQ-033 Buffer SHALL be sub-module pixel_fifo (synchronous, count output, flush input).

Verification
REQ-034 FRAME_PIXELS=4, base=0x100, data_ready 3 cycles after each re_ram, pix_ready=1 -> addrs 0x100..0x103 in order, 4 pixels out, single frame_done, busy low after.
REQ-035 pix_ready=0, FRAME_PIXELS=12, FIFO_DEPTH=8 -> 8 reads issued then re_ram held low; releasing pix_ready -> remaining 4 reads, 12 pixels in order.
REQ-036 base=0x3FFFFFE, FRAME_PIXELS=4 -> addrs 0x3FFFFFE, 0x3FFFFFF, 0x0000000, 0x0000001.
REQ-037 Reset asserted during WAIT of pixel 2 -> next cycle re_ram=0, pix_valid=0, busy=0; new start restarts at base.
REQ-038 With PIXEL_FETCH_TIMEOUT_EN and no data_ready -> re_ram low and err=1 after 255 cycles, busy=0, no frame_done; next start clears err.
